// File: rtl/l2_line_adapter_pkg.sv
// l2_pkg: shared types and sizing for the L2 line adapter and L2 controller
package l2_pkg;
   localparam int l2_s_offset = 5;
   localparam int l2_s_line   = 256;
   localparam int l2_s_burst  = 64;
   localparam int l2_s_addr   = 32;
   localparam int n_beats     = l2_s_line / l2_s_burst;
   typedef enum logic [1:0] {IDLE, FILL, WB, DONE} l2_adapt_state_t;
   typedef logic [$clog2(n_beats)-1:0] beat_cnt_t;
endpackage

// File: rtl/l2_line_adapter_if.sv
// l2_line_adapter_if: cache-side and memory-side signals of the line adapter
interface l2_line_adapter_if
   import l2_pkg::*;
#(
   parameter int s_addr  = l2_s_addr,
   parameter int s_line  = l2_s_line,
   parameter int s_burst = l2_s_burst
);
   logic [s_addr-1:0]  address_i;
   logic               read_i;
   logic               write_i;
   logic [s_line-1:0]  line_i;
   logic [s_line-1:0]  line_o;
   logic               resp_o;
   logic [s_addr-1:0]  address_o;
   logic               read_o;
   logic               write_o;
   logic [s_burst-1:0] burst_o;
   logic [s_burst-1:0] burst_i;
   logic               resp_i;
   modport master (
      output address_i, read_i, write_i, line_i, burst_i, resp_i,
      input  line_o, resp_o, address_o, read_o, write_o, burst_o
   );
   modport slave (
      input  address_i, read_i, write_i, line_i, burst_i, resp_i,
      output line_o, resp_o, address_o, read_o, write_o, burst_o
   );
endinterface

// File: rtl/l2_line_adapter_line_buffer.sv
// l2_line_buffer: one cache line with whole-line load and per-beat write/read
module l2_line_buffer #(
   parameter int s_line  = 256,
   parameter int s_burst = 64,
   parameter int cw      = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [s_line-1:0]  src,
   input  logic               wr,
   input  logic [cw-1:0]      idx,
   input  logic [s_burst-1:0] data,
   output logic [s_line-1:0]  q,
   output logic [s_burst-1:0] beat
);
   // whole-line load wins over a beat write; the two never coincide in practice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else if (load) q <= src;
      else if (wr) q[idx*s_burst +: s_burst] <= data;
   end
   assign beat = q[idx*s_burst +: s_burst];
endmodule

// File: rtl/l2_line_adapter.sv
// l2_line_adapter: converts whole L2 line fills/writebacks into memory bursts
module l2_line_adapter
   import l2_pkg::*;
#(
   parameter int s_offset = l2_s_offset,
   parameter int s_line   = l2_s_line,
   parameter int s_burst  = l2_s_burst,
   parameter int s_addr   = l2_s_addr
) (
   input logic              clk,
   input logic              rst_n,
   l2_line_adapter_if.slave bus
);
   localparam int nb = s_line / s_burst;
   localparam int cw = $clog2(nb);
   if (nb < 2 || (nb & (nb - 1)) != 0) begin : g_bad_beats
      $error("l2_line_adapter: n_beats must be a power of two, at least 2");
   end
   if (s_line != (8 << s_offset)) begin : g_bad_line
      $error("l2_line_adapter: s_line must equal 8 * 2**s_offset");
   end
   l2_adapt_state_t state, nxt;
   logic [cw-1:0]      cnt;
   logic [s_addr-1:0]  addr;
   logic [s_line-1:0]  buf_q, merged, line_q;
   logic [s_burst-1:0] rd_beat;
   logic               last, beat, accept;
   assign last   = cnt == cw'(nb - 1);
   assign beat   = bus.resp_i && (state == FILL || state == WB);
   assign accept = state == IDLE && (bus.read_i || bus.write_i);
   l2_line_buffer #(.s_line(s_line), .s_burst(s_burst), .cw(cw)) u_buf (
      .clk  (clk),
      .rst_n(rst_n),
      .load (state == IDLE && bus.write_i),
      .src  (bus.line_i),
      .wr   (state == FILL && bus.resp_i),
      .idx  (cnt),
      .data (bus.burst_i),
      .q    (buf_q),
      .beat (rd_beat)
   );
   // next state: writeback wins over fill; the last accepted beat ends the burst
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.write_i ? WB : bus.read_i ? FILL : IDLE;
         FILL:    nxt = beat && last ? DONE : FILL;
         WB:      nxt = beat && last ? DONE : WB;
         default: nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   end
   // the final fill beat is merged in here so line_o is already complete in DONE
   always_comb begin
      merged = buf_q;
      merged[cnt*s_burst +: s_burst] = bus.burst_i;
   end
   // beat counter, aligned address latch and published fill line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         addr   <= '0;
         line_q <= '0;
      end else begin
         if (beat) cnt <= last ? '0 : cnt + 1'b1;
         if (accept) addr <= {bus.address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
         if (state == FILL && bus.resp_i && last) line_q <= merged;
      end
   end
   assign bus.read_o    = state == FILL;
   assign bus.write_o   = state == WB;
   assign bus.resp_o    = state == DONE;
   assign bus.address_o = addr;
   assign bus.burst_o   = state == WB ? rd_beat : '0;
   assign bus.line_o    = line_q;
   a_no_resp_in_done: assert property (@(posedge clk) disable iff (!rst_n) !(state == DONE && bus.resp_i));
endmodule

// File: tb/tb_l2_line_adapter.sv
// tb_l2_line_adapter: randomized self-checking bench for the L2 line adapter
module tb_l2_line_adapter;
   localparam int SA = 32;
   localparam int SL = 256;
   localparam int SB = 64;
   localparam int NB = SL / SB;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [SL-1:0] exp_line = '0;
   always #5 clk = ~clk;
   l2_line_adapter_if #(.s_addr(SA), .s_line(SL), .s_burst(SB)) bus ();
   l2_line_adapter #(.s_offset(5), .s_line(SL), .s_burst(SB), .s_addr(SA)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   task automatic chk(input string tag, input logic [SL-1:0] got, input logic [SL-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [SB-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction
   function automatic logic [SL-1:0] rnd_line();
      logic [SL-1:0] l;
      for (int i = 0; i < NB; i++) l[i*SB +: SB] = rnd64();
      return l;
   endfunction
   // mode 0: beat every cycle, 1: random gaps, 2: fixed pattern 1,0,0,1,1,0,1
   task automatic xfer(input bit rd, input bit wr, input logic [SA-1:0] a, input logic [SL-1:0] ln, input int mode);
      logic [6:0] pat = 7'b1011001;
      logic [SA-1:0] exp_addr = a & ~32'h1f;
      bit is_wb = wr;
      bit r;
      int k = 0;
      int gaps = 0;
      int c = 0;
      chk("idle_busy", {bus.read_o, bus.write_o, bus.resp_o}, 0);
      bus.address_i = a;
      bus.read_i = rd;
      bus.write_i = wr;
      bus.line_i = ln;
      step();
      bus.read_i = 1'b0;
      bus.write_i = 1'b0;
      bus.line_i = ~ln;
      bus.address_i = $urandom;
      while (k < NB) begin
         chk("read_o", bus.read_o, !is_wb);
         chk("write_o", bus.write_o, is_wb);
         chk("address_o", bus.address_o, exp_addr);
         chk("resp_o_early", bus.resp_o, 0);
         if (is_wb) begin
            chk("burst_o", bus.burst_o, ln[k*SB +: SB]);
            chk("line_o_wb", bus.line_o, exp_line);
         end
         r = mode == 0 ? 1'b1 : mode == 2 ? pat[c] : (gaps >= 3 || $urandom_range(0, 2) != 0);
         bus.resp_i = r;
         bus.burst_i = r && !is_wb ? ln[k*SB +: SB] : rnd64();
         if (is_wb) bus.read_i = 1'($urandom);
         step();
         if (r) begin
            k++;
            gaps = 0;
         end else gaps++;
         c++;
      end
      bus.resp_i = 1'b0;
      bus.read_i = 1'b0;
      bus.burst_i = rnd64();
      if (!is_wb) exp_line = ln;
      chk("resp_o_done", bus.resp_o, 1);
      chk("done_rw", {bus.read_o, bus.write_o}, 0);
      chk("line_o_done", bus.line_o, exp_line);
      step();
      chk("resp_o_pulse", bus.resp_o, 0);
      chk("line_o_held", bus.line_o, exp_line);
   endtask
   // idle cycles with spurious memory handshakes that must be ignored
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.resp_i = 1'($urandom);
         bus.burst_i = rnd64();
         step();
         chk("idle_quiet", {bus.read_o, bus.write_o, bus.resp_o}, 0);
         chk("idle_line_o", bus.line_o, exp_line);
      end
      bus.resp_i = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.address_i = '0;
      bus.read_i = 1'b0;
      bus.write_i = 1'b0;
      bus.line_i = '0;
      bus.burst_i = '0;
      bus.resp_i = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 0);
      chk("rst_addr", bus.address_o, 0);
      chk("rst_burst", bus.burst_o, 0);
      chk("rst_line", bus.line_o, 0);
      xfer(1, 0, 32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0);
      xfer(0, 1, 32'h0000_8765, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 2);
      xfer(1, 1, $urandom, rnd_line(), 1);
      xfer(1, 0, $urandom, rnd_line(), 1);
      idle(6);
      bus.address_i = 32'h0000_4040;
      bus.read_i = 1'b1;
      step();
      bus.read_i = 1'b0;
      bus.resp_i = 1'b1;
      bus.burst_i = rnd64();
      step();
      bus.burst_i = rnd64();
      step();
      bus.resp_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_line = '0;
      chk("arst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 0);
      chk("arst_line", bus.line_o, 0);
      chk("arst_addr", bus.address_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_quiet", {bus.read_o, bus.write_o, bus.resp_o}, 0);
      end
      xfer(1, 0, 32'h0000_4040, rnd_line(), 0);
      for (int t = 0; t < 40; t++) begin
         int kind = $urandom_range(0, 2);
         xfer(kind != 1, kind != 0, $urandom, rnd_line(), $urandom_range(0, 1));
         if (kind == 2) xfer(1, 0, $urandom, rnd_line(), 1);
         idle($urandom_range(0, 3));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
